store_buffer: RTL and testbench

- Posted-write buffer between the MIPS core data port (memwrite/dataadr/writedata) and the data memory.
- Accepts a core store in one cycle, queues it, and drains it to memory over a valid/ready handshake, so a slow memory does not stall every store.
- Forwards the youngest buffered store data to core loads that hit a buffered word address.

---
 rtl/mips_mem_pkg.sv | 16 +
 rtl/store_buffer_fifo.sv | 63 ++++++
 rtl/store_buffer.sv | 77 +++++++
 tb/tb_store_buffer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory path: default widths,
// word-offset handling and the store-buffer entry type.
package mips_mem_pkg;
  localparam int SB_AW       = 32;
  localparam int SB_DW       = 32;
  localparam int WORD_OFFSET = 2;

  typedef struct packed {
    logic [SB_AW-1:0] adr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  function automatic logic [SB_AW-1:0] word_addr(input logic [SB_AW-1:0] adr);
    return {adr[SB_AW-1:WORD_OFFSET], {WORD_OFFSET{1'b0}}};
  endfunction
endpackage

// File: rtl/store_buffer_fifo.sv
// Circular store FIFO: pointers, occupancy count and the (unreset) entry array.
// Exposes the head plus every entry with its occupied flag for forwarding.
module store_buffer_fifo
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [AW-1:0]             i_adr,
  input  logic [DW-1:0]             i_data,
  output logic [AW-1:0]             o_head_adr,
  output logic [DW-1:0]             o_head_data,
  output logic [DEPTH-1:0][AW-1:0]  o_ent_adr,
  output logic [DEPTH-1:0][DW-1:0]  o_ent_data,
  output logic [DEPTH-1:0]          o_ent_vld,
  output logic [PW-1:0]             o_rd_ptr,
  output logic [CW-1:0]             o_count
);
  logic [PW-1:0]            r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]            r_count;
  logic [DEPTH-1:0][AW-1:0] r_adr;
  logic [DEPTH-1:0][DW-1:0] r_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // Payload storage carries no reset; occupancy comes only from the pointers.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_adr[r_wr_ptr]  <= i_adr;
      r_data[r_wr_ptr] <= i_data;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_vld
    logic [PW-1:0] w_off;
    assign w_off        = PW'(g) - r_rd_ptr;
    assign o_ent_vld[g] = {1'b0, w_off} < r_count;
  end

  assign o_head_adr  = r_adr[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];
  assign o_ent_adr   = r_adr;
  assign o_ent_data  = r_data;
  assign o_rd_ptr    = r_rd_ptr;
  assign o_count     = r_count;
endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core data port and data memory, with
// youngest-match load forwarding and a valid/ready drain toward memory.
module store_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_memwrite,
  input  logic                     cpu_memread,
  input  logic [AW-1:0]            cpu_adr,
  input  logic [DW-1:0]            cpu_wdata,
  output logic                     cpu_stall,
  output logic                     cpu_fwd_hit,
  output logic [DW-1:0]            cpu_fwd_data,
  output logic                     mem_wvalid,
  output logic [AW-1:0]            mem_wadr,
  output logic [DW-1:0]            mem_wdata,
  input  logic                     mem_wready,
  output logic [$clog2(DEPTH):0]   sb_count,
  output logic                     sb_empty,
  output logic                     sb_full
);
  localparam int PW = $clog2(DEPTH);

  logic                     w_push, w_pop;
  logic [AW-1:0]            w_wadr;
  logic [DEPTH-1:0][AW-1:0] w_ent_adr;
  logic [DEPTH-1:0][DW-1:0] w_ent_data;
  logic [DEPTH-1:0]         w_ent_vld;
  logic [PW-1:0]            w_rd_ptr;

  assign w_wadr     = {cpu_adr[AW-1:WORD_OFFSET], {WORD_OFFSET{1'b0}}};
  assign sb_empty   = (sb_count == '0);
  assign sb_full    = (sb_count == ($clog2(DEPTH)+1)'(DEPTH));
  assign mem_wvalid = !sb_empty;
  assign w_pop      = mem_wvalid & mem_wready;
  assign w_push     = cpu_memwrite & (!sb_full | w_pop);
  assign cpu_stall  = cpu_memwrite & sb_full & !w_pop;

  store_buffer_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_adr       (w_wadr),
    .i_data      (cpu_wdata),
    .o_head_adr  (mem_wadr),
    .o_head_data (mem_wdata),
    .o_ent_adr   (w_ent_adr),
    .o_ent_data  (w_ent_data),
    .o_ent_vld   (w_ent_vld),
    .o_rd_ptr    (w_rd_ptr),
    .o_count     (sb_count)
  );

  // Walk entries oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    cpu_fwd_hit  = 1'b0;
    cpu_fwd_data = '0;
    idx          = '0;
    if (cpu_memread) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx = w_rd_ptr + PW'(k);
        if (w_ent_vld[idx] &&
            w_ent_adr[idx][AW-1:WORD_OFFSET] == cpu_adr[AW-1:WORD_OFFSET]) begin
          cpu_fwd_hit  = 1'b1;
          cpu_fwd_data = w_ent_data[idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, drain, full/stall, forwarding
// and backpressure ordering, each as its own task.
module tb_store_buffer;
  import mips_mem_pkg::*;

  logic        clk = 0;
  logic        reset;
  logic        cpu_memwrite, cpu_memread;
  logic [31:0] cpu_adr, cpu_wdata;
  logic        cpu_stall, cpu_fwd_hit;
  logic [31:0] cpu_fwd_data;
  logic        mem_wvalid;
  logic [31:0] mem_wadr, mem_wdata;
  logic        mem_wready;
  logic [2:0]  sb_count;
  logic        sb_empty, sb_full;

  int checks = 0;
  int errors = 0;
  int cycno  = 0;
  int viol   = 0;

  sb_entry_t wlog[$];
  int        wcyc[$];
  logic        r_hold;
  logic [31:0] r_hadr, r_hdata;

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
    .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_fwd_hit(cpu_fwd_hit), .cpu_fwd_data(cpu_fwd_data),
    .mem_wvalid(mem_wvalid), .mem_wadr(mem_wadr), .mem_wdata(mem_wdata),
    .mem_wready(mem_wready),
    .sb_count(sb_count), .sb_empty(sb_empty), .sb_full(sb_full)
  );

  always #5 clk = ~clk;

  // Memory-side monitor: logs accepted writes and checks head stability.
  always @(posedge clk) begin
    cycno <= cycno + 1;
    if (reset && mem_wvalid && mem_wready) begin
      wlog.push_back('{adr: mem_wadr, data: mem_wdata});
      wcyc.push_back(cycno);
    end
    if (!reset) r_hold <= 1'b0;
    else begin
      if (r_hold && mem_wvalid && (mem_wadr !== r_hadr || mem_wdata !== r_hdata))
        viol <= viol + 1;
      r_hold  <= mem_wvalid && !mem_wready;
      r_hadr  <= mem_wadr;
      r_hdata <= mem_wdata;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cpu_memwrite = 0; cpu_memread = 0; cpu_adr = 0; cpu_wdata = 0;
  endtask

  task automatic drain();
    idle(); mem_wready = 1;
    repeat (6) cyc();
  endtask

  task automatic test_reset();
    idle(); mem_wready = 0; reset = 0;
    #1;
    checks++;
    if ({mem_wvalid, sb_empty, sb_full, sb_count, cpu_stall, cpu_fwd_hit} !== 8'b0_1_0_000_0_0 ||
        cpu_fwd_data !== 0) begin
      errors++;
      $display("FAIL reset_state: valid=%b empty=%b full=%b count=%0d stall=%b hit=%b fdata=%h, required 0 1 0 0 0 0 0",
               mem_wvalid, sb_empty, sb_full, sb_count, cpu_stall, cpu_fwd_hit, cpu_fwd_data);
    end
    cyc(); reset = 1; cyc();
    // three stores held by backpressure, then an async reset between edges
    for (int i = 0; i < 3; i++) begin
      cpu_memwrite = 1; cpu_adr = 32'h100 + 4*i; cpu_wdata = 32'hA0 + i;
      cyc();
    end
    idle();
    checks++;
    if (sb_count !== 3) begin
      errors++; $display("FAIL reset_pre_count: got %0d want 3", sb_count);
    end
    #1 reset = 0;
    #1;
    checks++;
    if (sb_count !== 0 || mem_wvalid !== 0) begin
      errors++; $display("FAIL reset_async: count=%0d valid=%b want 0 0", sb_count, mem_wvalid);
    end
    #2 reset = 1;
    wlog.delete(); wcyc.delete();
    mem_wready = 1;
    repeat (4) cyc();
    checks++;
    if (wlog.size() !== 0) begin
      errors++; $display("FAIL reset_no_write: got %0d writes want 0", wlog.size());
    end
    mem_wready = 0;
  endtask

  task automatic test_basic_drain();
    int stalls = 0;
    wlog.delete(); wcyc.delete();
    mem_wready = 1;
    cpu_memwrite = 1; cpu_adr = 80; cpu_wdata = 7;
    #1 if (cpu_stall) stalls++;
    cyc();
    cpu_adr = 84; cpu_wdata = 7;
    #1 if (cpu_stall) stalls++;
    cyc();
    idle();
    repeat (3) cyc();
    checks++;
    if (stalls !== 0) begin
      errors++; $display("FAIL basic_stall: stalled %0d times want 0", stalls);
    end
    checks++;
    if (wlog.size() !== 2) begin
      errors++; $display("FAIL basic_count: got %0d writes want 2", wlog.size());
    end else begin
      checks++;
      if (wlog[0].adr !== 80 || wlog[0].data !== 7 || wlog[1].adr !== 84 || wlog[1].data !== 7) begin
        errors++; $display("FAIL basic_order: got (%0d,%0d)(%0d,%0d) want (80,7)(84,7)",
                           wlog[0].adr, wlog[0].data, wlog[1].adr, wlog[1].data);
      end
      checks++;
      if (wcyc[1] - wcyc[0] !== 1) begin
        errors++; $display("FAIL basic_consec: gap %0d want 1", wcyc[1] - wcyc[0]);
      end
    end
    checks++;
    if (sb_empty !== 1) begin
      errors++; $display("FAIL basic_empty: got %b want 1", sb_empty);
    end
  endtask

  task automatic test_full_stall();
    wlog.delete(); wcyc.delete();
    mem_wready = 0;
    for (int i = 0; i < 4; i++) begin
      cpu_memwrite = 1; cpu_adr = 4*i; cpu_wdata = 100 + 4*i;
      cyc();
    end
    cpu_adr = 16; cpu_wdata = 116;
    #1;
    checks++;
    if (sb_full !== 1 || sb_count !== 4) begin
      errors++; $display("FAIL full_flag: full=%b count=%0d want 1 4", sb_full, sb_count);
    end
    checks++;
    if (cpu_stall !== 1) begin
      errors++; $display("FAIL full_stall: got %b want 1", cpu_stall);
    end
    mem_wready = 1;
    #1;
    checks++;
    if (cpu_stall !== 0 || mem_wadr !== 0) begin
      errors++; $display("FAIL full_pop_accept: stall=%b head=%0d want 0 0", cpu_stall, mem_wadr);
    end
    cyc();
    idle(); mem_wready = 0;
    #1;
    checks++;
    if (sb_count !== 4 || wlog.size() !== 1) begin
      errors++; $display("FAIL full_swap: count=%0d writes=%0d want 4 1", sb_count, wlog.size());
    end
    drain();
    checks++;
    if (wlog.size() !== 5) begin
      errors++; $display("FAIL full_drain_n: got %0d want 5", wlog.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (wlog[i].adr !== 4*i || wlog[i].data !== 100 + 4*i) begin
          errors++; $display("FAIL full_order[%0d]: got (%0d,%0d) want (%0d,%0d)",
                             i, wlog[i].adr, wlog[i].data, 4*i, 100 + 4*i);
        end
      end
    end
  endtask

  task automatic test_forward();
    mem_wready = 0;
    cpu_memwrite = 1; cpu_adr = 84; cpu_wdata = 5; cyc();
    cpu_adr = 84; cpu_wdata = 7;
    cpu_memread = 0;
    #1;
    checks++;
    if (cpu_fwd_hit !== 0 || cpu_fwd_data !== 0) begin
      errors++; $display("FAIL fwd_noread: hit=%b data=%0d want 0 0", cpu_fwd_hit, cpu_fwd_data);
    end
    cyc();
    idle(); cpu_memread = 1; cpu_adr = 86;
    #1;
    checks++;
    if (cpu_fwd_hit !== 1 || cpu_fwd_data !== 7) begin
      errors++; $display("FAIL fwd_youngest: hit=%b data=%0d want 1 7", cpu_fwd_hit, cpu_fwd_data);
    end
    cpu_adr = 88;
    #1;
    checks++;
    if (cpu_fwd_hit !== 0 || cpu_fwd_data !== 0) begin
      errors++; $display("FAIL fwd_miss: hit=%b data=%0d want 0 0", cpu_fwd_hit, cpu_fwd_data);
    end
    // an entry being popped this cycle is still forwarded
    cpu_adr = 84; mem_wready = 1;
    #1;
    checks++;
    if (cpu_fwd_hit !== 1 || cpu_fwd_data !== 7) begin
      errors++; $display("FAIL fwd_popping: hit=%b data=%0d want 1 7", cpu_fwd_hit, cpu_fwd_data);
    end
    drain();
  endtask

  task automatic test_backpressure();
    sb_entry_t exp[$];
    int n = 0;
    int over = 0;
    logic [31:0] a, d;
    wlog.delete(); wcyc.delete();
    viol = 0;
    a = word_addr(32'($urandom_range(0, 63)) << 2 | 32'($urandom_range(0, 3)));
    d = $urandom;
    for (int c = 0; c < 60 && n < 16; c++) begin
      mem_wready = c[0];
      cpu_memwrite = 1; cpu_adr = a | 32'(c % 4); cpu_wdata = d;
      #1;
      if (sb_count > 4) over++;
      if (!cpu_stall) begin
        exp.push_back('{adr: word_addr(cpu_adr), data: cpu_wdata});
        n++;
        a = word_addr(32'($urandom_range(0, 63)) << 2);
        d = $urandom;
      end
      cyc();
    end
    idle();
    for (int c = 0; c < 12; c++) begin
      mem_wready = c[0];
      #1 if (sb_count > 4) over++;
      cyc();
    end
    mem_wready = 1; repeat (4) cyc();
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL bp_stable: %0d head changes under backpressure want 0", viol);
    end
    checks++;
    if (over !== 0) begin
      errors++; $display("FAIL bp_count_max: count exceeded 4 %0d times want 0", over);
    end
    checks++;
    if (wlog.size() !== exp.size() || n !== 16) begin
      errors++; $display("FAIL bp_len: writes=%0d stores=%0d pushed=%0d want equal and 16",
                         wlog.size(), exp.size(), n);
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (wlog[i] !== exp[i]) begin
          errors++; $display("FAIL bp_seq[%0d]: got (%h,%h) want (%h,%h)",
                             i, wlog[i].adr, wlog[i].data, exp[i].adr, exp[i].data);
        end
      end
    end
    checks++;
    if (sb_empty !== 1) begin
      errors++; $display("FAIL bp_empty: got %b want 1", sb_empty);
    end
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_full_stall();
    test_forward();
    test_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 ns");
    $fatal(1);
  end
endmodule
